// File: rtl/spi_flash_reader_pkg.sv
// spi_flash_pkg: state encoding, opcodes and address width shared by the SPI flash reader.
package spi_flash_pkg;
  localparam int ADDR_W = 24;
  localparam logic [7:0] SPI_CMD_READ = 8'h03;
  localparam logic [7:0] SPI_CMD_FAST_READ = 8'h0B;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, HOLD} state_t;
endpackage

// File: rtl/spi_flash_reader_if.sv
// spi_flash_reader_if: request and read-byte stream between the application and the flash reader.
interface spi_flash_reader_if #(parameter int LEN_W = 16);
  import spi_flash_pkg::*;
  logic req_valid;
  logic req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0] req_len;
  logic [7:0] rd_data;
  logic rd_valid;
  logic rd_ready;
  logic done;
  logic busy;
  modport master (output req_valid, req_addr, req_len, rd_ready, input req_ready, rd_data, rd_valid, done, busy);
  modport slave (input req_valid, req_addr, req_len, rd_ready, output req_ready, rd_data, rd_valid, done, busy);
endinterface

// File: rtl/spi_sck_gen.sv
// spi_sck_gen: SCK divider with rise/fall strobes marking the clk edge on which SCK toggles.
module spi_sck_gen #(parameter int CLK_DIV = 1) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [CW-1:0] cnt;
  logic tick;
  always_comb begin
    tick = en && cnt == CW'(CLK_DIV - 1);
    rise = tick && !sck;
    fall = tick && sck;
  end
  // Disabling restarts the phase so a resumed SCK always gets a full low half-period.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      sck <= 1'b0;
    end else begin
      cnt <= (!en || tick) ? '0 : cnt + 1'b1;
      if (tick) sck <= !sck;
    end
endmodule

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: SPI mode-0 NOR flash reader streaming bytes over valid/ready.
// SPI_FLASH_READER_FAST_READ_EN selects FAST_READ (0x0B) with 8 dummy clocks.
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV = 1,
  parameter int CS_HOLD = 2,
  parameter int LEN_W = 16
) (
  input  logic clk,
  input  logic rst,
  spi_flash_reader_if.slave bus,
  output logic spi_csel,
  output logic spi_clk,
  output logic spi_mosi,
  input  logic spi_miso
);
`ifdef SPI_FLASH_READER_FAST_READ_EN
  localparam logic [7:0] OPCODE = SPI_CMD_FAST_READ;
  localparam state_t AFTER_ADDR = DUMMY;
`else
  localparam logic [7:0] OPCODE = SPI_CMD_READ;
  localparam state_t AFTER_ADDR = DATA;
`endif
  localparam int HW = CS_HOLD > 1 ? $clog2(CS_HOLD) : 1;
  state_t state, nxt;
  logic [31:0] tx;
  logic [7:0] rx;
  logic [4:0] cnt;
  logic [LEN_W-1:0] len;
  logic [HW-1:0] hold_cnt;
  logic pend, out_free, en, last, hold_done, rise, fall;
  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (.clk, .rst, .en, .sck(spi_clk), .rise, .fall);
  // pend marks a complete byte still in rx; SCK freezes low until the output register frees.
  always_comb begin
    out_free = !bus.rd_valid || bus.rd_ready;
    en = state != IDLE && state != HOLD && !(pend && !out_free);
    last = cnt == (state == ADDR ? 5'd23 : 5'd7);
    nxt = state == CMD ? ADDR : state == ADDR ? AFTER_ADDR : DATA;
    hold_done = hold_cnt == HW'(CS_HOLD - 1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      tx <= '0;
      rx <= '0;
      cnt <= '0;
      len <= '0;
      hold_cnt <= '0;
      pend <= 1'b0;
      bus.req_ready <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.rd_data <= '0;
      bus.rd_valid <= 1'b0;
      spi_csel <= 1'b1;
      spi_mosi <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (bus.rd_valid && bus.rd_ready) bus.rd_valid <= 1'b0;
      if (pend && out_free) begin
        bus.rd_data <= rx;
        bus.rd_valid <= 1'b1;
        pend <= 1'b0;
      end
      case (state)
        IDLE: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            bus.busy <= 1'b1;
            len <= bus.req_len;
            cnt <= '0;
            hold_cnt <= '0;
            tx <= {OPCODE, bus.req_addr};
            spi_mosi <= OPCODE[7] && bus.req_len != '0;
            spi_csel <= bus.req_len == '0;
            state <= bus.req_len == '0 ? HOLD : CMD;
          end
        end
        CMD, ADDR, DUMMY: if (fall) begin
          tx <= tx << 1;
          spi_mosi <= tx[30];
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) state <= nxt;
        end
        DATA: begin
          if (rise) rx <= {rx[6:0], spi_miso};
          if (fall) begin
            cnt <= last ? '0 : cnt + 1'b1;
            if (last) begin
              pend <= 1'b1;
              len <= len - 1'b1;
              if (len == LEN_W'(1)) begin
                state <= HOLD;
                spi_csel <= 1'b1;
              end
            end
          end
        end
        HOLD: begin
          hold_cnt <= hold_done ? hold_cnt : hold_cnt + 1'b1;
          if (hold_done && !pend && out_free) begin
            state <= IDLE;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            bus.req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader: randomized reads against a behavioural SPI NOR flash and a byte scoreboard.
module tb_spi_flash_reader;
  localparam int CLK_DIV = 1;
  localparam int CS_HOLD = 2;
  localparam int LEN_W = 16;
`ifdef SPI_FLASH_READER_FAST_READ_EN
  localparam logic [7:0] OP = 8'h0B;
  localparam int DUM = 8;
`else
  localparam logic [7:0] OP = 8'h03;
  localparam int DUM = 0;
`endif
  localparam int LAT = 2 * (8 + 24 + DUM) * CLK_DIV + 16 * CLK_DIV + 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_csel, spi_clk, spi_mosi;
  logic spi_miso = 1'b0;
  spi_flash_reader_if #(.LEN_W(LEN_W)) bus ();
  spi_flash_reader #(.CLK_DIV(CLK_DIV), .CS_HOLD(CS_HOLD), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .spi_csel(spi_csel), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  logic [7:0] mem [logic [23:0]];
  function automatic logic [7:0] fbyte(input logic [23:0] a);
    return mem.exists(a) ? mem[a] : (a[7:0] ^ {a[11:8], a[15:12]} ^ a[23:16] ^ 8'h5A);
  endfunction
  // Flash: samples mosi on SCK rise, shifts data out on SCK fall, address wraps at 24 bits.
  int fbits = 0;
  int fk;
  int dum_hi = 0;
  logic [31:0] fcap = '0;
  logic [7:0] fb;
  always @(posedge spi_csel) fbits = 0;
  always @(posedge spi_clk)
    if (!spi_csel) begin
      if (fbits < 32) fcap = {fcap[30:0], spi_mosi};
      else if (fbits < 32 + DUM && spi_mosi) dum_hi++;
      fbits++;
    end
  always @(negedge spi_clk)
    if (!spi_csel && fbits >= 32 + DUM) begin
      fk = fbits - 32 - DUM;
      fb = fbyte(fcap[23:0] + 24'(fk / 8));
      spi_miso = fb[3'(7 - fk % 8)];
    end
  int cyc = 0, acc_cyc = 0, first_cyc = -1, done_cnt = 0, sck_edges = 0, csel_falls = 0;
  int hi_run = 0, min_hi = 1000, rr_pct = 100;
  bit rr_block = 0;
  logic prev_sck = 1'b0, prev_csel = 1'b1;
  logic [7:0] got [$];
  always @(negedge clk) begin
    cyc++;
    if (bus.req_valid && bus.req_ready) begin
      acc_cyc = cyc + 1;
      first_cyc = -1;
    end
    if (bus.rd_valid && first_cyc < 0) first_cyc = cyc;
    if (bus.done) done_cnt++;
    if (spi_clk !== prev_sck) sck_edges++;
    if (!spi_csel && prev_csel) begin
      csel_falls++;
      if (hi_run < min_hi) min_hi = hi_run;
    end
    hi_run = spi_csel ? hi_run + 1 : 0;
    prev_sck = spi_clk;
    prev_csel = spi_csel;
    bus.rd_ready = !rr_block && ($urandom_range(99) < rr_pct);
    if (bus.rd_valid && bus.rd_ready && !rst) got.push_back(bus.rd_data);
  end
  task automatic start_req(input logic [23:0] a, input logic [LEN_W-1:0] l);
    int t = 0;
    @(posedge clk); #1;
    while (!bus.req_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) check("req_ready_timeout", 0, 1);
    got.delete();
    done_cnt = 0;
    bus.req_addr = a;
    bus.req_len = l;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("busy_after_accept", {bus.busy, bus.req_ready}, 2'b10);
  endtask
  task automatic finish_req(input logic [23:0] a, input logic [LEN_W-1:0] l, input string tag);
    int t = 0;
    while (done_cnt == 0 && t < 20000) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (CS_HOLD + 4) @(posedge clk);
    #1;
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_byte_count"}, got.size(), l);
    for (int i = 0; i < got.size() && i < int'(l); i++) check({tag, "_data"}, got[i], fbyte(a + 24'(i)));
    if (l != 0) begin
      check({tag, "_latency"}, first_cyc - acc_cyc, LAT);
      check({tag, "_mosi_cmd_addr"}, fcap, {OP, a});
    end
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [23:0] a;
    logic [LEN_W-1:0] l;
    int e1, cf, t;
    bus.req_valid = 1'b0;
    bus.req_addr = '0;
    bus.req_len = '0;
    bus.rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {bus.req_ready, bus.rd_valid, bus.rd_data, bus.done, bus.busy, spi_csel, spi_clk, spi_mosi},
          {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", {bus.req_ready, bus.busy}, 2'b10);
    mem[24'h123456] = 8'hDE; mem[24'h123457] = 8'hAD; mem[24'h123458] = 8'hBE; mem[24'h123459] = 8'hEF;
    start_req(24'h123456, 4);
    finish_req(24'h123456, 4, "read1");
    check("read1_literal_b0", got.size() > 0 ? got[0] : 8'h00, 8'hDE);
    check("read1_literal_b3", got.size() > 3 ? got[3] : 8'h00, 8'hEF);
    rr_block = 1;
    start_req(24'h0ABCDE, 3);
    t = 0;
    while (first_cyc < 0 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (20) @(posedge clk);
    #1;
    e1 = sck_edges;
    repeat (20) @(posedge clk);
    #1;
    check("stall_sck_edges", sck_edges - e1, 0);
    check("stall_sck_low", spi_clk, 1'b0);
    rr_block = 0;
    finish_req(24'h0ABCDE, 3, "backpressure");
    cf = csel_falls;
    start_req(24'h001000, 0);
    t = 1;
    while (!bus.req_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("zero_ready_return", t <= CS_HOLD + 1, 1'b1);
    finish_req(24'h001000, 0, "zero");
    check("zero_csel_falls", csel_falls - cf, 0);
    for (int i = 0; i < 4; i++) mem[24'hFFFFFE + 24'(i)] = 8'($urandom());
    start_req(24'hFFFFFE, 4);
    finish_req(24'hFFFFFE, 4, "wrap");
    start_req(24'h000200, 4);
    t = 0;
    while (got.size() < 1 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (4) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_csel_async", spi_csel, 1'b1);
    check("rst_mid_outputs", {bus.req_ready, bus.rd_valid, bus.rd_data, bus.done, bus.busy, spi_csel, spi_clk, spi_mosi},
          {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    @(posedge clk); #1;
    rst = 1'b0;
    start_req(24'h000010, 1);
    finish_req(24'h000010, 1, "after_reset");
`ifdef SPI_FLASH_READER_FAST_READ_EN
    start_req(24'h000100, 2);
    finish_req(24'h000100, 2, "fast");
    check("fast_dummy_mosi_low", dum_hi, 0);
`endif
    for (int i = 0; i < 10; i++) begin
      rr_pct = $urandom_range(100, 40);
      a = (i % 3 == 0) ? 24'hFFFFFC + 24'($urandom_range(3)) : 24'($urandom());
      l = LEN_W'($urandom_range(5));
      start_req(a, l);
      finish_req(a, l, "random");
    end
    check("csel_min_high", min_hi >= CS_HOLD, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
